mem_port_arbiter: RTL

Shares the core's single memory port between instruction fetch (IF stage) and the load/store unit (FU_LSU uops in EX). Only one transaction is outstanding at a time. LSU has priority, with a bounded-streak rule so IF cannot starve. The block sits between the IF/LSU request interfaces and the external memory request/response channel.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// One transaction in flight; LSU has priority, bounded by a streak limit so IF cannot starve.
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [XLEN-1:0]   ifu_req_addr,
    output logic              ifu_rsp_valid,
    output logic [XLEN-1:0]   ifu_rsp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [XLEN-1:0]   lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [XLEN-1:0]   lsu_req_wdata,
    input  logic [XLEN/8-1:0] lsu_req_wmask,
    output logic              lsu_rsp_valid,
    output logic [XLEN-1:0]   lsu_rsp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,

    output logic              busy
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t        state;
    state_t        state_next;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic          streak_full;
    logic          grant_ifu;
    logic          grant_lsu;
    logic          rsp_fire;

    assign streak_full = (streak == STREAK_MAX);

    // Arbitration is purely combinational on the valids; grants are masked while
    // rst_n is low so every output reads 0 during reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_ifu  = 1'b0;
        grant_lsu  = 1'b0;
        state_next = state;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    if (lsu_req_valid && !(ifu_req_valid && streak_full)) begin
                        grant_lsu = 1'b1;
                    end else if (ifu_req_valid) begin
                        grant_ifu = 1'b1;
                    end
                end
                if (grant_lsu || grant_ifu) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (mem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_IF;
            streak        <= '0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            state <= state_next;
            if (grant_lsu) begin
                owner         <= OWN_LSU;
                mem_req_addr  <= lsu_req_addr;
                mem_req_wen   <= lsu_req_wen;
                mem_req_wdata <= lsu_req_wdata;
                mem_req_wmask <= lsu_req_wmask;
                // Only a waiting IF request extends the streak; otherwise it restarts.
                if (ifu_req_valid) begin
                    streak <= streak_full ? streak : streak + SW'(1);
                end else begin
                    streak <= '0;
                end
            end else if (grant_ifu) begin
                owner         <= OWN_IF;
                mem_req_addr  <= ifu_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wmask <= '1;
                streak        <= '0;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);

    // Responses outside RSP are spurious and simply ignored.
    assign rsp_fire      = (state == RSP) && mem_rsp_valid;
    assign ifu_rsp_valid = rsp_fire && (owner == OWN_IF);
    assign lsu_rsp_valid = rsp_fire && (owner == OWN_LSU);
    assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_rdata : '0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? mem_rsp_rdata : '0;

endmodule
